// File: rtl/credit_tx_pkg.sv
// credit_tx_pkg
// Shared definitions for the credit-based link transmitter:
//   - state_e          : drain sequencer states (RUN, DRAIN, DONE)
//   - DEF_INFLIGHT_IDX : default log2 of receiver slot count
//   - DEF_SIZE         : default payload width
//   - inflight_of()    : slot count for a given log2 index
package credit_tx_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEF_INFLIGHT_IDX = 2;
    localparam int DEF_SIZE         = 4;

    function automatic int inflight_of(input int idx);
        return 1 << idx;
    endfunction

endpackage

// File: rtl/credit_tx_if.sv
// credit_tx_if
// Bundles the upstream handshake, the link beat, the credit return and the
// flush/status signals of credit_tx.
//   slave  : transmitter view (credit_tx)
//   master : environment view (upstream source + link receiver + control)
// Signals:
//   in_val/in_rdy/in_data    upstream handshake and payload
//   out_val/out_data         link beat (no back-pressure)
//   credit_ret               one pulse per receiver slot freed
//   flush/flush_done         drain request (level) / completion (pulse)
//   credit_cnt               credits currently available
//   err                      sticky credit-overflow flag
interface credit_tx_if
    import credit_tx_pkg::*;
#(
    parameter int INFLIGHT_IDX = DEF_INFLIGHT_IDX,
    parameter int SIZE         = DEF_SIZE
);
    logic                    in_val;
    logic                    in_rdy;
    logic [SIZE-1:0]         in_data;
    logic                    out_val;
    logic [SIZE-1:0]         out_data;
    logic                    credit_ret;
    logic                    flush;
    logic                    flush_done;
    logic [INFLIGHT_IDX:0]   credit_cnt;
    logic                    err;

    modport slave (
        input  in_val, in_data, credit_ret, flush,
        output in_rdy, out_val, out_data, flush_done, credit_cnt, err
    );

    modport master (
        output in_val, in_data, credit_ret, flush,
        input  in_rdy, out_val, out_data, flush_done, credit_cnt, err
    );
endinterface

// File: rtl/credit_ctr.sv
// credit_ctr
// Saturating credit counter. Starts full after reset; inc returns a credit,
// dec consumes one, both together cancel. A return while already full is
// dropped and latches overflow until reset.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : credit returned this cycle
//   dec        : credit consumed this cycle (caller guarantees count != 0)
//   count      : credits available
//   overflow   : sticky overflow flag
module credit_ctr #(
    parameter int INFLIGHT_IDX = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic                  dec,
    output logic [INFLIGHT_IDX:0] count,
    output logic                  overflow
);
    localparam logic [INFLIGHT_IDX:0] FULL = (INFLIGHT_IDX+1)'(2**INFLIGHT_IDX);

    logic [INFLIGHT_IDX:0] count_q, count_d;
    logic                  ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (inc && !dec) begin
            if (count_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dec && !inc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= FULL;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign overflow = ovf_q;
endmodule

// File: rtl/credit_tx.sv
// credit_tx
// Credit-based link transmitter. Upstream beats are accepted while credits
// remain and forwarded one cycle later on a link that has no ready; the
// receiver returns one credit per slot it frees. A flush request stops
// acceptance and waits until every credit is back and the link is idle,
// then pulses flush_done for one cycle.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : credit_tx_if.slave (handshake, link, credits, flush, status)
module credit_tx
    import credit_tx_pkg::*;
#(
    parameter int INFLIGHT_IDX = DEF_INFLIGHT_IDX,
    parameter int SIZE         = DEF_SIZE
) (
    input  logic         clk,
    input  logic         rst_n,
    credit_tx_if.slave   bus
);
    localparam logic [INFLIGHT_IDX:0] FULL =
        (INFLIGHT_IDX+1)'(inflight_of(INFLIGHT_IDX));

    state_e                state_q, state_d;
    logic                  out_val_q;
    logic [SIZE-1:0]       out_data_q;
    logic                  flush_done_q;
    logic [INFLIGHT_IDX:0] credit_cnt;
    logic                  overflow;
    logic                  rdy;
    logic                  send;

    // Ready depends only on registered state and flush, never on in_val.
    assign rdy  = (state_q == ST_RUN) && !bus.flush && (credit_cnt != '0);
    assign send = bus.in_val && rdy;

    credit_ctr #(
        .INFLIGHT_IDX(INFLIGHT_IDX)
    ) u_credit_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (bus.credit_ret),
        .dec      (send),
        .count    (credit_cnt),
        .overflow (overflow)
    );

    // The drain is complete once all slots are free and no beat is still
    // on the link (a beat in flight has not yet consumed its slot view).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (bus.flush) state_d = ST_DRAIN;
            ST_DRAIN: if (credit_cnt == FULL && !out_val_q) state_d = ST_DONE;
            ST_DONE:  state_d = bus.flush ? ST_DRAIN : ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            out_val_q    <= 1'b0;
            out_data_q   <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_val_q    <= send;
            if (send) begin
                out_data_q <= bus.in_data;
            end
            // Registered so that it is high exactly while in DONE.
            flush_done_q <= (state_d == ST_DONE);
        end
    end

    assign bus.in_rdy     = rdy;
    assign bus.out_val    = out_val_q;
    assign bus.out_data   = out_data_q;
    assign bus.flush_done = flush_done_q;
    assign bus.credit_cnt = credit_cnt;
    assign bus.err        = overflow;
endmodule

// File: tb/tb_credit_tx.sv
module tb_credit_tx;
    localparam int IDX  = 2;
    localparam int SIZE = 4;
    localparam int INFL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    credit_tx_if #(.INFLIGHT_IDX(IDX), .SIZE(SIZE)) bus();

    credit_tx #(.INFLIGHT_IDX(IDX), .SIZE(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: credits as a plain integer, the link as "last beat",
    // the flush sequence as a mode number (0 accepting, 1 draining, 2 done).
    int         m_cnt;
    bit         m_err;
    bit         m_oval;
    logic [3:0] m_odata;
    int         m_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt   = INFL;
        m_err   = 1'b0;
        m_oval  = 1'b0;
        m_odata = '0;
        m_mode  = 0;
    endtask

    task automatic check_outputs();
        check("credit_cnt", 32'(bus.credit_cnt), 32'(m_cnt));
        check("out_val",    32'(bus.out_val),    32'(m_oval));
        check("out_data",   32'(bus.out_data),   32'(m_odata));
        check("err",        32'(bus.err),        32'(m_err));
        check("flush_done", 32'(bus.flush_done), 32'(m_mode == 2));
    endtask

    // Called 1 time unit after a rising edge; applies inputs for one cycle.
    task automatic cycle(input bit iv, input logic [3:0] id, input bit cr, input bit fl);
        bit exp_rdy;
        bit send;
        int nxt;
        bus.in_val     = iv;
        bus.in_data    = id;
        bus.credit_ret = cr;
        bus.flush      = fl;
        #1;
        exp_rdy = (m_mode == 0) && !fl && (m_cnt > 0);
        check("in_rdy", 32'(bus.in_rdy), 32'(exp_rdy));
        send = iv && exp_rdy;
        if (m_mode == 1) nxt = (m_cnt == INFL && !m_oval) ? 2 : 1;
        else             nxt = fl ? 1 : 0;
        m_cnt = m_cnt - int'(send) + int'(cr);
        if (m_cnt > INFL) begin
            m_cnt = INFL;
            m_err = 1'b1;
        end
        m_oval = send;
        if (send) m_odata = id;
        m_mode = nxt;
        @(posedge clk);
        #1;
        check_outputs();
        $display("t=%0t val=%0d data=%0h ret=%0d flush=%0d sent=%0d cnt=%0d done=%0d",
                 $time, iv, id, cr, fl, send, m_cnt, m_mode == 2);
    endtask

    // Asynchronous reset applied mid-cycle, checked before any clock edge.
    task automatic do_reset();
        bus.in_val = 1'b0; bus.credit_ret = 1'b0; bus.flush = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int fl_hold;

    initial begin
        bus.in_val = 1'b0; bus.in_data = '0; bus.credit_ret = 1'b0; bus.flush = 1'b0;
        #2;
        do_reset();

        // Credit exhaustion
        for (int i = 1; i <= 6; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
        check("exhaust_cnt", 32'(bus.credit_cnt), 32'd0);

        // Credit return restores ready next cycle, data 5 goes out
        cycle(1'b1, 4'd5, 1'b1, 1'b0);
        cycle(1'b1, 4'd5, 1'b0, 1'b0);
        check("return_data", 32'(bus.out_data), 32'd5);

        // Simultaneous send and return at count 2
        cycle(1'b0, 4'd0, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b1, 1'b0);
        cycle(1'b1, 4'd9, 1'b1, 1'b0);
        check("simul_cnt", 32'(bus.credit_cnt), 32'd2);

        // Overflow at full credits, err sticky
        cycle(1'b0, 4'd0, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0);
        check("err_sticky", 32'(bus.err), 32'd1);

        // Flush when already empty: done two cycles later
        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
        check("quick_done", 32'(bus.flush_done), 32'd1);
        cycle(1'b0, 4'd0, 1'b0, 1'b0);

        // Flush with three beats outstanding
        do_reset();
        for (int i = 1; i <= 3; i++) cycle(1'b1, 4'(i + 10), 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) cycle(1'b1, 4'hA, (k == 5 || k == 7 || k == 9), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0);

        // Reset in the middle of a drain
        for (int i = 1; i <= 3; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        check("drain_cnt", 32'(bus.credit_cnt), 32'd1);
        do_reset();
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b0);

        // Random traffic with random returns and flush bursts
        fl_hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (fl_hold == 0 && $urandom_range(0, 24) == 0) fl_hold = $urandom_range(1, 8);
            cycle(1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 2) == 0, fl_hold != 0);
            if (fl_hold != 0) fl_hold--;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/credit_tx.md
CREDIT_TX -- requirements
Module: credit_tx

Interface
REQ-001 The block SHALL have parameter INFLIGHT_IDX, default 2, giving log2 of the downstream slot count (INFLIGHT = 2**INFLIGHT_IDX credits).
REQ-002 The block SHALL have parameter SIZE, default 4, giving the data width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_val  input  1  upstream data valid.
REQ-006 in_rdy  output  1  block accepts in_data this cycle.
REQ-007 in_data  input  SIZE  upstream payload.
REQ-008 out_val  output  1  link beat valid; the link has no ready, and the receiver FIFO is guaranteed a free slot by credits.
REQ-009 out_data  output  SIZE  link payload.
REQ-010 credit_ret  input  1  one-cycle pulse per slot freed at the receiver (one pop).
REQ-011 flush  input  1  level request to drain all outstanding beats.
REQ-012 flush_done  output  1  one-cycle pulse when the drain completes.
REQ-013 credit_cnt  output  INFLIGHT_IDX+1  credits currently available.
REQ-014 err  output  1  sticky credit-overflow flag.

Function
REQ-015 A send SHALL occur in a cycle with in_val && in_rdy.
REQ-016 in_rdy SHALL be 1 only when credit_cnt != 0 and the FSM is in RUN with flush low; it is combinational from registers and flush only, never from in_val.
REQ-017 On a send, out_val SHALL be 1 and out_data SHALL equal the accepted in_data in the next cycle (latency 1); otherwise out_val SHALL be 0 and out_data SHALL hold its value.
REQ-018 credit_cnt SHALL decrement by 1 on send without credit_ret.
REQ-019 credit_cnt SHALL increment by 1 on credit_ret without send.
REQ-020 credit_cnt SHALL be unchanged on simultaneous send and credit_ret.
REQ-021 credit_cnt SHALL never exceed INFLIGHT.
REQ-022 A credit_ret with no send while credit_cnt == INFLIGHT SHALL leave credit_cnt at INFLIGHT and set err, which stays 1 until reset.
REQ-023 credit_cnt == 0 SHALL deassert in_rdy in the same cycle; a credit_ret in that cycle restores in_rdy in the next cycle.
REQ-024 The FSM SHALL have states RUN, DRAIN and DONE.
REQ-025 RUN -> DRAIN when flush is 1; in_rdy is 0 in that cycle and in every DRAIN and DONE cycle.
REQ-026 DRAIN -> DONE when credit_cnt == INFLIGHT and out_val == 0.
REQ-027 DONE SHALL last one cycle with flush_done = 1, then return to RUN; flush_done is 0 in all other states.
REQ-028 If flush is still 1 in DONE, the FSM SHALL re-enter DRAIN and not RUN; a fresh drain then completes immediately when already empty.
REQ-029 Asserting flush with credit_cnt == INFLIGHT and out_val == 0 SHALL produce flush_done exactly 2 cycles later (RUN -> DRAIN -> DONE).

Reset
REQ-030 While rst_n is 0, the block SHALL immediately and asynchronously set: credit_cnt = INFLIGHT; out_val = 0; out_data = 0; err = 0; flush_done = 0; FSM = RUN.
REQ-031 Reset during DRAIN SHALL abandon the drain with no flush_done, and the block SHALL restart in RUN with full credits.
REQ-032 The first send SHALL be possible in the first cycle after rst_n rises.

Structure
REQ-033 A shared package SHALL hold the FSM state enumeration (RUN, DRAIN, DONE) and the default INFLIGHT_IDX and SIZE constants.
REQ-034 The credit arithmetic SHALL be one sub-module, credit_ctr (inc, dec, count, overflow), instantiated once.
REQ-035 The total implementation SHALL be 120-400 lines of RTL.

Verification (INFLIGHT_IDX=2, SIZE=4)
REQ-036 Credit exhaustion: after reset, in_val=1 for 6 cycles with data 1..6 and no credit_ret -> beats 1,2,3,4 appear on out_val 1 cycle after acceptance; in_rdy=0 from the 5th cycle; credit_cnt=0.
REQ-037 Credit return: from the REQ-036 end state, one credit_ret pulse -> credit_cnt=1, in_rdy=1 the next cycle, and data 5 is sent.
REQ-038 Simultaneous send and return: credit_cnt=2, send and credit_ret in the same cycle -> credit_cnt stays 2, out_val=1 next cycle.
REQ-039 Overflow: credit_cnt=4, credit_ret pulse with no send -> credit_cnt=4 and err=1, and err stays 1 for 10 further cycles.
REQ-040 Flush: 3 beats outstanding, flush held 1, credit_ret pulsed 3 times at cycles 5, 7, 9 -> in_rdy=0 throughout and flush_done=1 exactly one cycle after credit_cnt reaches 4.
REQ-041 Reset mid-drain: rst_n asserted in DRAIN with credit_cnt=1 -> credit_cnt=4, out_val=0, no flush_done, in_rdy=1 after release with flush=0.
